// File: rtl/sfifo_sp_ctrl.sv
// sfifo_sp_ctrl: pointer/counter owner and port arbiter for a synchronous FIFO
// built on a single-port SRAM (sfifo_mem). The one SRAM port is shared between
// pushes and prefetch reads. A 2-entry output buffer hides the 1-cycle read
// latency and presents a first-word-fall-through valid/ready read side.
//
// Optional feature macro: SFIFO_SP_BYPASS_EN
//   When defined, a push into an otherwise empty pipeline (nothing in SRAM,
//   no read in flight, room in the buffer) skips the SRAM and lands directly
//   in the output buffer, so the data is visible one cycle after the push.
//
// There is no encoded FSM. The control state is:
//   register | meaning
//   wr_ptr   | next SRAM write address
//   rd_ptr   | next SRAM prefetch address
//   mem_cnt  | words held in SRAM (0..DEPTH)
//   inflight | SRAM read issued last cycle, data arrives this cycle
//   buf_cnt  | valid words in the output buffer (0..2)
//   prio_wr  | who wins the next write/read conflict (1 = write)
`timescale 1ns/1ps

module sfifo_sp_ctrl #(
  parameter int BW     = 48,
  parameter int LGFLEN = 8
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  output logic              o_wr_ready,
  output logic              o_rd_valid,
  output logic [BW-1:0]     o_rd_data,
  input  logic              i_rd,
  output logic [LGFLEN+1:0] o_fill,
  output logic              o_mem_wr,
  output logic [LGFLEN-1:0] o_mem_wr_addr,
  output logic [BW-1:0]     o_mem_data,
  output logic              o_mem_rd,
  output logic [LGFLEN-1:0] o_mem_rd_addr,
  input  logic [BW-1:0]     i_mem_data
);

  logic [LGFLEN-1:0] wr_ptr;
  logic [LGFLEN-1:0] rd_ptr;
  logic [LGFLEN:0]   mem_cnt;
  logic              inflight;
  logic              prio_wr;
  logic [BW-1:0]     buf0;
  logic [BW-1:0]     buf1;
  logic [1:0]        buf_cnt;

  logic              pop;
  logic              mem_full;
  logic              mem_empty;
  logic [1:0]        occ_after;
  logic              rd_req;
  logic              wr_req;
  logic              byp;
  logic              gnt_wr;
  logic              gnt_rd;
  logic              append;
  logic [BW-1:0]     app_data;

  assign pop       = o_rd_valid && i_rd;
  // mem_cnt never exceeds DEPTH, so its MSB alone marks a full SRAM
  assign mem_full  = mem_cnt[LGFLEN];
  assign mem_empty = (mem_cnt == '0);
  // buffer occupancy including the word already on its way from the SRAM;
  // buf_cnt + inflight never exceeds 2, so this cannot wrap
  assign occ_after = buf_cnt + {1'b0, inflight} - {1'b0, pop};

  assign rd_req = !mem_empty && (occ_after < 2'd2);
  assign wr_req = i_wr && !mem_full;

  // ready only looks at i_wr-independent terms, keeping i_wr out of its cone
  assign o_wr_ready = !mem_full && !(rd_req && !prio_wr);

  // request arbitration and bypass decision
  always_comb begin
    byp    = 1'b0;
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
`ifdef SFIFO_SP_BYPASS_EN
    byp    = wr_req && mem_empty && !inflight && ((buf_cnt - {1'b0, pop}) < 2'd2);
`endif
    gnt_wr = wr_req && !byp && (!rd_req || prio_wr);
    gnt_rd = rd_req && (!wr_req || !prio_wr);
  end

  // a bypass push can only happen with nothing in flight, so the sources never clash
  assign append   = inflight || byp;
  assign app_data = inflight ? i_mem_data : i_data;

  assign o_mem_wr      = gnt_wr;
  assign o_mem_rd      = gnt_rd;
  assign o_mem_wr_addr = wr_ptr;
  assign o_mem_rd_addr = rd_ptr;
  assign o_mem_data    = i_data;

  assign o_rd_valid = (buf_cnt != 2'd0);
  assign o_rd_data  = buf0;

  assign o_fill = {1'b0, mem_cnt}
                + {{(LGFLEN+1){1'b0}}, inflight}
                + {{LGFLEN{1'b0}}, buf_cnt};

  // pointers, SRAM occupancy, read-in-flight flag and conflict priority
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
      prio_wr  <= 1'b1;
    end else begin
      inflight <= gnt_rd;
      if (gnt_wr) wr_ptr <= wr_ptr + 1'b1;
      if (gnt_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({gnt_wr, gnt_rd})
        2'b10:   mem_cnt <= mem_cnt + 1'b1;
        2'b01:   mem_cnt <= mem_cnt - 1'b1;
        default: mem_cnt <= mem_cnt;
      endcase
      if (rd_req && wr_req) prio_wr <= !prio_wr;
    end
  end

  // two-entry output buffer: pop shifts buf1 down, append fills the first free slot
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      buf0    <= '0;
      buf1    <= '0;
      buf_cnt <= 2'd0;
    end else begin
      case ({pop, append})
        2'b10: begin
          buf0    <= buf1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd0) buf0 <= app_data;
          else                 buf1 <= app_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf0 <= app_data;
          end else begin
            buf0 <= buf1;
            buf1 <= app_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sfifo_sp_ctrl.sv
`timescale 1ns/1ps

module tb_sfifo_sp_ctrl;

  localparam int BW     = 48;
  localparam int LGFLEN = 8;
  localparam int DEPTH  = 1 << LGFLEN;

  logic              clk = 1'b0;
  logic              i_reset_n;
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              o_wr_ready;
  logic              o_rd_valid;
  logic [BW-1:0]     o_rd_data;
  logic              i_rd;
  logic [LGFLEN+1:0] o_fill;
  logic              o_mem_wr;
  logic [LGFLEN-1:0] o_mem_wr_addr;
  logic [BW-1:0]     o_mem_data;
  logic              o_mem_rd;
  logic [LGFLEN-1:0] o_mem_rd_addr;
  logic [BW-1:0]     i_mem_data;

  always #5 clk = ~clk;

  sfifo_sp_ctrl #(.BW(BW), .LGFLEN(LGFLEN)) dut (
    .i_clk        (clk),
    .i_reset_n    (i_reset_n),
    .i_wr         (i_wr),
    .i_data       (i_data),
    .o_wr_ready   (o_wr_ready),
    .o_rd_valid   (o_rd_valid),
    .o_rd_data    (o_rd_data),
    .i_rd         (i_rd),
    .o_fill       (o_fill),
    .o_mem_wr     (o_mem_wr),
    .o_mem_wr_addr(o_mem_wr_addr),
    .o_mem_data   (o_mem_data),
    .o_mem_rd     (o_mem_rd),
    .o_mem_rd_addr(o_mem_rd_addr),
    .i_mem_data   (i_mem_data)
  );

  // single-port SRAM with one-cycle read latency
  logic [BW-1:0] mem [DEPTH];
  logic [BW-1:0] mem_q;
  always @(posedge clk) begin
    if (o_mem_wr) mem[o_mem_wr_addr] <= o_mem_data;
    if (o_mem_rd) mem_q <= mem[o_mem_rd_addr];
  end
  assign i_mem_data = mem_q;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: FIFO contents as an ordered queue of accepted pushes
  logic [BW-1:0] model_q[$];

  logic              obs_valid, obs_ready, obs_mw, obs_mr, did_pop;
  logic [BW-1:0]     obs_data, pop_got, pop_exp;
  logic [LGFLEN+1:0] obs_fill;
  logic [LGFLEN-1:0] obs_wa, obs_ra;
  int                exp_fill;

  function automatic logic [BW-1:0] rnd_word();
    return BW'({$urandom(), $urandom()});
  endfunction

  // drive one cycle, sample outputs before the next rising edge, advance the model
  task automatic step(input logic w, input logic [BW-1:0] d, input logic r);
    @(negedge clk);
    i_wr = w; i_data = d; i_rd = r;
    #1;
    obs_valid = o_rd_valid; obs_data = o_rd_data; obs_fill = o_fill;
    obs_ready = o_wr_ready; obs_mw = o_mem_wr; obs_mr = o_mem_rd;
    obs_wa = o_mem_wr_addr; obs_ra = o_mem_rd_addr;
    exp_fill = model_q.size();
    did_pop = o_rd_valid && r;
    if (did_pop) begin
      pop_got = o_rd_data;
      if (model_q.size() != 0) pop_exp = model_q.pop_front();
      else pop_exp = 'x;
    end
    if (w && o_wr_ready) model_q.push_back(d);
  endtask

  task automatic apply_reset();
    i_reset_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_data = '0;
    repeat (2) @(negedge clk);
    model_q.delete();
    #2 i_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", o_rd_valid); end
    n_checks++; if (o_fill !== '0) begin n_fail++; $display("FAIL reset_fill got=%0d exp=0", o_fill); end
    n_checks++; if (o_mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr got=%b exp=0", o_mem_wr); end
    n_checks++; if (o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd got=%b exp=0", o_mem_rd); end
    n_checks++; if (o_wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", o_wr_ready); end
    n_checks++; if (o_rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0", o_rd_data); end
  endtask

  task automatic test_single_push();
    apply_reset();
    step(1'b1, 48'hA1, 1'b0);
`ifdef SFIFO_SP_BYPASS_EN
    n_checks++; if (obs_mw !== 1'b0) begin n_fail++; $display("FAIL single_c0_mem_wr got=%b exp=0", obs_mw); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL single_c1_valid got=%b exp=1", obs_valid); end
    n_checks++; if (obs_data !== 48'hA1) begin n_fail++; $display("FAIL single_c1_data got=%h exp=a1", obs_data); end
    step(1'b0, '0, 1'b0);
`else
    n_checks++; if (obs_mw !== 1'b1 || obs_wa !== '0) begin n_fail++; $display("FAIL single_c0_mem_wr got=%b@%0d exp=1@0", obs_mw, obs_wa); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_mr !== 1'b1 || obs_ra !== '0) begin n_fail++; $display("FAIL single_c1_mem_rd got=%b@%0d exp=1@0", obs_mr, obs_ra); end
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_c1_valid got=%b exp=0", obs_valid); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_c2_valid got=%b exp=0", obs_valid); end
`endif
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1 || obs_data !== 48'hA1) begin n_fail++; $display("FAIL single_c3_head got=%b/%h exp=1/a1", obs_valid, obs_data); end
    n_checks++; if (obs_fill !== 10'd1) begin n_fail++; $display("FAIL single_c3_fill got=%0d exp=1", obs_fill); end
    step(1'b0, '0, 1'b1);
    n_checks++; if (!did_pop || pop_got !== 48'hA1) begin n_fail++; $display("FAIL single_pop got=%b/%h exp=1/a1", did_pop, pop_got); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_fill !== 10'd0 || obs_valid !== 1'b0) begin n_fail++; $display("FAIL single_empty got=%0d/%b exp=0/0", obs_fill, obs_valid); end
  endtask

`ifdef SFIFO_SP_BYPASS_EN
  task automatic test_bypass();
    apply_reset();
    step(1'b1, 48'h5, 1'b0);
    n_checks++; if (obs_mw !== 1'b0) begin n_fail++; $display("FAIL bypass_c0_mem_wr got=%b exp=0", obs_mw); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_valid !== 1'b1 || obs_data !== 48'h5) begin n_fail++; $display("FAIL bypass_c1_head got=%b/%h exp=1/5", obs_valid, obs_data); end
    n_checks++; if (obs_mw !== 1'b0 || obs_fill !== 10'd1) begin n_fail++; $display("FAIL bypass_c1_state got=%b/%0d exp=0/1", obs_mw, obs_fill); end
  endtask
`endif

  task automatic test_fill_full();
    int cyc;
    apply_reset();
    cyc = 0;
    while (model_q.size() < DEPTH + 2 && cyc < 3000) begin
      step(1'b1, rnd_word(), 1'b0);
      n_checks++; if (obs_fill !== 10'(exp_fill)) begin n_fail++; $display("FAIL full_fill got=%0d exp=%0d", obs_fill, exp_fill); end
      n_checks++; if (obs_mw && obs_mr) begin n_fail++; $display("FAIL full_port_clash got=both exp=one"); end
      cyc++;
    end
    n_checks++; if (cyc >= 3000) begin n_fail++; $display("FAIL full_timeout got=%0d exp=%0d", model_q.size(), DEPTH + 2); end
    repeat (3) begin
      step(1'b0, '0, 1'b0);
      n_checks++; if (obs_fill !== 10'(DEPTH + 2) || obs_ready !== 1'b0 || obs_valid !== 1'b1) begin
        n_fail++; $display("FAIL full_hold got=%0d/%b/%b exp=%0d/0/1", obs_fill, obs_ready, obs_valid, DEPTH + 2);
      end
    end
    step(1'b1, 48'hDEAD, 1'b0);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", obs_ready); end
    step(1'b0, '0, 1'b0);
    n_checks++; if (obs_fill !== 10'(DEPTH + 2)) begin n_fail++; $display("FAIL full_ignored_push got=%0d exp=%0d", obs_fill, DEPTH + 2); end
    cyc = 0;
    while (model_q.size() > 0 && cyc < 3000) begin
      step(1'b0, '0, 1'($urandom_range(0, 1)));
      n_checks++; if (obs_fill !== 10'(exp_fill)) begin n_fail++; $display("FAIL full_drain_fill got=%0d exp=%0d", obs_fill, exp_fill); end
      if (did_pop) begin
        n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL full_drain_data got=%h exp=%h", pop_got, pop_exp); end
      end
      cyc++;
    end
    n_checks++; if (cyc >= 3000) begin n_fail++; $display("FAIL full_drain_timeout got=%0d exp=0", model_q.size()); end
  endtask

  task automatic test_alternate();
    int cyc;
    logic prev_mw;
    apply_reset();
    cyc = 0;
    while (model_q.size() < DEPTH / 2 && cyc < 1000) begin
      step(1'b1, rnd_word(), 1'b0);
      cyc++;
    end
    n_checks++; if (cyc >= 1000) begin n_fail++; $display("FAIL alt_prefill_timeout got=%0d exp=%0d", model_q.size(), DEPTH / 2); end
    repeat (4) step(1'b0, '0, 1'b0);
    prev_mw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, rnd_word(), 1'b1);
      n_checks++; if (obs_mw && obs_mr) begin n_fail++; $display("FAIL alt_port_clash cyc=%0d got=both exp=one", i); end
      if (i > 0) begin
        n_checks++; if ((obs_mw ^ obs_mr) !== 1'b1 || obs_mw === prev_mw) begin
          n_fail++; $display("FAIL alt_pattern cyc=%0d got=wr%b rd%b prev_wr%b exp=alternating", i, obs_mw, obs_mr, prev_mw);
        end
      end
      prev_mw = obs_mw;
      n_checks++; if (obs_fill !== 10'(exp_fill)) begin n_fail++; $display("FAIL alt_fill got=%0d exp=%0d", obs_fill, exp_fill); end
      if (did_pop) begin
        n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL alt_data got=%h exp=%h", pop_got, pop_exp); end
      end
    end
    cyc = 0;
    while (model_q.size() > 0 && cyc < 2000) begin
      step(1'b0, '0, 1'b1);
      if (did_pop) begin
        n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL alt_drain_data got=%h exp=%h", pop_got, pop_exp); end
      end
      cyc++;
    end
    n_checks++; if (cyc >= 2000) begin n_fail++; $display("FAIL alt_drain_timeout got=%0d exp=0", model_q.size()); end
  endtask

  task automatic test_wrap();
    int sent, next_rx, cyc, mw_cnt, mr_cnt;
    apply_reset();
    sent = 0; next_rx = 0; cyc = 0; mw_cnt = 0; mr_cnt = 0;
    while ((sent < 600 || model_q.size() > 0) && cyc < 6000) begin
      step(1'(sent < 600), BW'(sent), 1'($urandom_range(0, 3) != 0));
      if (i_wr && obs_ready) sent++;
      n_checks++; if (obs_fill !== 10'(exp_fill)) begin n_fail++; $display("FAIL wrap_fill got=%0d exp=%0d", obs_fill, exp_fill); end
      if (obs_mw) begin
        n_checks++; if (obs_wa !== LGFLEN'(mw_cnt)) begin n_fail++; $display("FAIL wrap_wr_addr got=%0d exp=%0d", obs_wa, mw_cnt % DEPTH); end
        mw_cnt++;
      end
      if (obs_mr) begin
        n_checks++; if (obs_ra !== LGFLEN'(mr_cnt)) begin n_fail++; $display("FAIL wrap_rd_addr got=%0d exp=%0d", obs_ra, mr_cnt % DEPTH); end
        mr_cnt++;
      end
      if (did_pop) begin
        n_checks++; if (pop_got !== BW'(next_rx) || pop_got !== pop_exp) begin
          n_fail++; $display("FAIL wrap_data got=%0d exp=%0d", pop_got, next_rx);
        end
        next_rx++;
      end
      cyc++;
    end
    n_checks++; if (next_rx != 600) begin n_fail++; $display("FAIL wrap_count got=%0d exp=600", next_rx); end
    n_checks++; if (mw_cnt <= DEPTH) begin n_fail++; $display("FAIL wrap_no_wrap got=%0d exp=>%0d", mw_cnt, DEPTH); end
  endtask

  task automatic test_async_reset();
    int cyc;
    logic first_seen;
    apply_reset();
    for (int i = 0; i < 20; i++) step(1'b1, BW'(48'h100 + i), 1'(i > 10));
    @(negedge clk);
    #3;
    i_reset_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0;
    #1;
    n_checks++; if (o_rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid got=%b exp=0", o_rd_valid); end
    n_checks++; if (o_fill !== '0) begin n_fail++; $display("FAIL areset_fill got=%0d exp=0", o_fill); end
    n_checks++; if (o_mem_wr !== 1'b0 || o_mem_rd !== 1'b0) begin n_fail++; $display("FAIL areset_strobes got=%b%b exp=00", o_mem_wr, o_mem_rd); end
    model_q.delete();
    @(negedge clk);
    #2 i_reset_n = 1'b1;
    step(1'b1, 48'h77, 1'b0);
    step(1'b1, 48'h78, 1'b0);
    first_seen = 1'b0;
    cyc = 0;
    while (model_q.size() > 0 && cyc < 20) begin
      step(1'b0, '0, 1'b1);
      n_checks++; if (obs_fill !== 10'(exp_fill)) begin n_fail++; $display("FAIL areset_fill_after got=%0d exp=%0d", obs_fill, exp_fill); end
      if (did_pop) begin
        if (!first_seen) begin
          n_checks++; if (pop_got !== 48'h77) begin n_fail++; $display("FAIL areset_first got=%h exp=77", pop_got); end
          first_seen = 1'b1;
        end
        n_checks++; if (pop_got !== pop_exp) begin n_fail++; $display("FAIL areset_data got=%h exp=%h", pop_got, pop_exp); end
      end
      cyc++;
    end
    n_checks++; if (cyc >= 20) begin n_fail++; $display("FAIL areset_timeout got=%0d exp=0", model_q.size()); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset_n = 1'b0; i_wr = 1'b0; i_rd = 1'b0; i_data = '0;
    test_reset();
    test_single_push();
`ifdef SFIFO_SP_BYPASS_EN
    test_bypass();
`endif
    test_fill_full();
    test_alternate();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
